// File: rtl/image_stream_tx.sv
// Frame-buffer reader: streams a packed 8-bit greyscale frame from a 16-bit SRAM
// in raster order, with optional per-row blanking, a pause input and SOF/EOL/done marks.
module image_stream_tx #(
   parameter int COLS = 640,
   parameter int ROWS = 480,
   parameter int HGAP = 0,
   parameter int AW   = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          pause,
   output logic          busy,
   output logic          done,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [15:0]   mem_rdata,
   output logic          out_valid,
   output logic [15:0]   out_data,
   output logic          out_sof,
   output logic          out_eol
);

   localparam int WPR = COLS / 2;
   localparam int NW  = WPR * ROWS;
   localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int GW  = (HGAP > 1) ? $clog2(HGAP) : 1;

   localparam logic [AW-1:0] LAST_WORD = AW'(NW - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(WPR - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] GAP    = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   logic [1:0]    state;
   logic [AW-1:0] wcnt;
   logic [CW-1:0] col;
   logic [GW-1:0] gcnt;

   logic          sof0, eol0, last0;
   logic          v1, sof1, eol1, last1;

   logic          issue;
   logic [AW-1:0] idx;
   logic [CW-1:0] cidx;
   logic          is_eol, is_last;

   // The start edge itself issues word 0, so the first read follows start by one cycle.
   always_comb begin
      issue = 1'b0;
      idx   = wcnt;
      cidx  = col;
      case (state)
         IDLE: begin
            if (start) begin
               issue = 1'b1;
               idx   = '0;
               cidx  = '0;
            end
         end
         STREAM:  issue = !pause;
         default: issue = 1'b0;
      endcase
      is_eol  = (cidx == LAST_COL);
      is_last = (idx == LAST_WORD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         wcnt     <= '0;
         col      <= '0;
         gcnt     <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         sof0     <= 1'b0;
         eol0     <= 1'b0;
         last0    <= 1'b0;
      end else begin
         mem_rd <= issue;
         sof0   <= issue && (idx == '0);
         eol0   <= issue && is_eol;
         last0  <= issue && is_last;

         if (issue) begin
            mem_addr <= idx;
            wcnt     <= idx + AW'(1);
            col      <= is_eol ? '0 : cidx + CW'(1);
            if (is_last) begin
               state <= DRAIN;
            end else if (is_eol && (HGAP > 0)) begin
               state <= GAP;
               gcnt  <= GW'(HGAP - 1);
            end else begin
               state <= STREAM;
            end
         end else begin
            case (state)
               GAP: begin
                  if (gcnt == '0) state <= STREAM;
                  else            gcnt  <= gcnt - GW'(1);
               end
               DRAIN: begin
                  if (done) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end

         if ((state == IDLE) && start) busy <= 1'b1;
      end
   end

   // Two-stage return pipe: markers travel alongside the read strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         sof1      <= 1'b0;
         eol1      <= 1'b0;
         last1     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         done      <= 1'b0;
      end else begin
         v1        <= mem_rd;
         sof1      <= sof0;
         eol1      <= eol0;
         last1     <= last0;
         out_valid <= v1;
         out_data  <= v1 ? mem_rdata : '0;
         out_sof   <= sof1;
         out_eol   <= eol1;
         done      <= last1;
      end
   end

endmodule

// File: tb/tb_image_stream_tx.sv
// Bench for image_stream_tx: three instances (8x2, 8x2 with row gap 3, 640x32) checked
// every cycle against a word-level schedule model, plus hand-computed literal checks.
module tb_image_stream_tx;

   localparam int NI = 3;
   localparam int WPRA [NI] = '{4, 4, 320};
   localparam int NWA  [NI] = '{8, 8, 10240};
   localparam int HGA  [NI] = '{0, 3, 0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_s [NI];
   logic        pause_s [NI];
   logic        busy_s  [NI];
   logic        done_s  [NI];
   logic        rd_s    [NI];
   logic [17:0] addr_s  [NI];
   logic [15:0] rdata_s [NI];
   logic        val_s   [NI];
   logic [15:0] data_s  [NI];
   logic        sof_s   [NI];
   logic        eol_s   [NI];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   image_stream_tx #(.COLS(8), .ROWS(2), .HGAP(0), .AW(18)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .pause(pause_s[0]), .busy(busy_s[0]),
      .done(done_s[0]), .mem_rd(rd_s[0]), .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
      .out_valid(val_s[0]), .out_data(data_s[0]), .out_sof(sof_s[0]), .out_eol(eol_s[0]));

   image_stream_tx #(.COLS(8), .ROWS(2), .HGAP(3), .AW(18)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .pause(pause_s[1]), .busy(busy_s[1]),
      .done(done_s[1]), .mem_rd(rd_s[1]), .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
      .out_valid(val_s[1]), .out_data(data_s[1]), .out_sof(sof_s[1]), .out_eol(eol_s[1]));

   image_stream_tx #(.COLS(640), .ROWS(32), .HGAP(0), .AW(18)) dut2 (
      .clk(clk), .rst(rst), .start(start_s[2]), .pause(pause_s[2]), .busy(busy_s[2]),
      .done(done_s[2]), .mem_rd(rd_s[2]), .mem_addr(addr_s[2]), .mem_rdata(rdata_s[2]),
      .out_valid(val_s[2]), .out_data(data_s[2]), .out_sof(sof_s[2]), .out_eol(eol_s[2]));

   function automatic logic [15:0] word(input int n);
      logic [7:0] hi, lo;
      hi = 8'(2 * n);
      lo = 8'(2 * n + 1);
      return {hi, lo};
   endfunction

   task automatic check(input string nm, input int inst, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s (dut%0d) at cycle %0d: got 0x%0h, expected 0x%0h", nm, inst, cyc, act, exp);
      end
   endtask

   // Synchronous SRAM: data for the address presented with mem_rd appears next cycle.
   always @(posedge clk)
      for (int i = 0; i < NI; i++)
         if (rd_s[i]) rdata_s[i] <= word(int'(addr_s[i]));

   // Schedule model: which word index is read, and which is delivered, each cycle (-1 = none).
   int m_busy [NI], m_drain [NI], m_gap [NI], m_next [NI], m_addr [NI];
   int m_rd [NI], m_p1 [NI], m_p2 [NI];

   always @(posedge clk or posedge rst) begin : model
      int iss, b, d, g, nx, a;
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            m_busy[i] <= 0; m_drain[i] <= 0; m_gap[i] <= 0; m_next[i] <= 0; m_addr[i] <= 0;
            m_rd[i] <= -1; m_p1[i] <= -1; m_p2[i] <= -1;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            b = m_busy[i]; d = m_drain[i]; g = m_gap[i]; nx = m_next[i]; a = m_addr[i];
            iss = -1;
            if (b == 0) begin
               if (start_s[i]) begin b = 1; iss = 0; end
            end else if (d != 0) begin
               if (m_p2[i] == NWA[i] - 1) begin b = 0; d = 0; end
            end else if (g > 0) begin
               g = g - 1;
            end else if (!pause_s[i]) begin
               iss = nx;
            end
            if (iss >= 0) begin
               nx = iss + 1;
               a  = iss;
               if (iss == NWA[i] - 1) d = 1;
               else if ((iss % WPRA[i] == WPRA[i] - 1) && HGA[i] > 0) g = HGA[i];
            end
            m_busy[i] <= b; m_drain[i] <= d; m_gap[i] <= g; m_next[i] <= nx; m_addr[i] <= a;
            m_p2[i] <= m_p1[i]; m_p1[i] <= m_rd[i]; m_rd[i] <= iss;
         end
      end
   end

   always @(negedge clk) begin : compare
      for (int i = 0; i < NI; i++) begin
         check("busy",      i, longint'(busy_s[i]), longint'(m_busy[i] != 0));
         check("mem_rd",    i, longint'(rd_s[i]),   longint'(m_rd[i] >= 0));
         check("mem_addr",  i, longint'(addr_s[i]), longint'(m_addr[i]));
         check("out_valid", i, longint'(val_s[i]),  longint'(m_p2[i] >= 0));
         check("out_sof",   i, longint'(sof_s[i]),  longint'(m_p2[i] == 0));
         check("out_eol",   i, longint'(eol_s[i]),
               longint'(m_p2[i] >= 0 && (m_p2[i] % WPRA[i] == WPRA[i] - 1)));
         check("done",      i, longint'(done_s[i]), longint'(m_p2[i] == NWA[i] - 1));
         if (m_p2[i] >= 0) check("out_data", i, longint'(data_s[i]), longint'(word(m_p2[i])));
      end
   end

   logic [18:0] cap0 [$];
   logic [18:0] cap1 [$];
   int t0 [$];
   int t1 [$];
   int cnt_v = 0, cnt_eol = 0, cnt_done = 0, last_addr = -1;

   always @(negedge clk) begin : capture
      if (val_s[0]) begin cap0.push_back({sof_s[0], eol_s[0], done_s[0], data_s[0]}); t0.push_back(cyc); end
      if (val_s[1]) begin cap1.push_back({sof_s[1], eol_s[1], done_s[1], data_s[1]}); t1.push_back(cyc); end
      if (val_s[2]) cnt_v++;
      if (val_s[2] && eol_s[2]) cnt_eol++;
      if (done_s[2]) cnt_done++;
      if (rd_s[2]) last_addr = int'(addr_s[2]);
   end

   logic [15:0] lit [8] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607,
                            16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start(input int i);
      start_s[i] = 1'b1;
      tick(1);
      start_s[i] = 1'b0;
   endtask

   task automatic check_frame0(input string nm, input int base);
      for (int k = 0; k < 8; k++) begin
         check({nm, "_data"}, 0, longint'(cap0[base + k][15:0]), longint'(lit[k]));
         check({nm, "_flags"}, 0, longint'(cap0[base + k][18:16]),
               longint'({k == 0, (k == 3) || (k == 7), k == 7}));
      end
   endtask

   initial begin : stim
      int c0, ndone, guard;
      for (int i = 0; i < NI; i++) begin start_s[i] = 1'b0; pause_s[i] = 1'b0; end
      tick(2);
      check("rst_busy", 0, longint'(busy_s[0]), 0);
      check("rst_addr", 0, longint'(addr_s[0]), 0);
      check("rst_valid", 0, longint'(val_s[0]), 0);
      rst = 1'b0;
      tick(2);

      // Basic frame
      c0 = cyc + 1;
      pulse_start(0);
      tick(14);
      check("t1_count", 0, cap0.size(), 8);
      if (cap0.size() == 8) begin
         check_frame0("t1", 0);
         check("t1_first_lat", 0, t0[0] - c0, 2);
         check("t1_span", 0, t0[7] - t0[0], 7);
      end
      check("t1_busy_end", 0, longint'(busy_s[0]), 0);
      cap0.delete(); t0.delete();

      // Row gap of 3
      pulse_start(1);
      tick(20);
      check("t2_count", 1, cap1.size(), 8);
      if (cap1.size() == 8) begin
         check("t2_eol_word", 1, longint'(cap1[3][15:0]), 16'h0607);
         check("t2_next_word", 1, longint'(cap1[4][15:0]), 16'h0809);
         check("t2_hole", 1, t1[4] - t1[3], 4);
         check("t2_span", 1, t1[7] - t1[0] + 1, 11);
      end

      // Pause for 4 cycles after address 2 is issued
      pulse_start(0);
      tick(2);
      pause_s[0] = 1'b1;
      tick(4);
      pause_s[0] = 1'b0;
      tick(20);
      check("t3_count", 0, cap0.size(), 8);
      if (cap0.size() == 8) begin
         check_frame0("t3", 0);
         check("t3_hole", 0, t0[3] - t0[2], 5);
         check("t3_span", 0, t0[7] - t0[0], 11);
      end
      cap0.delete(); t0.delete();

      // Starts while busy (mid-frame and on done) are ignored; a start after busy falls is not
      pulse_start(0);
      tick(3);
      pulse_start(0);
      guard = 0;
      while (!done_s[0] && guard < 40) begin tick(1); guard++; end
      check("t4_done_timeout", 0, longint'(guard < 40), 1);
      start_s[0] = 1'b1;
      tick(1);
      start_s[0] = 1'b0;
      tick(1);
      pulse_start(0);
      tick(20);
      check("t4_count", 0, cap0.size(), 16);
      if (cap0.size() == 16) begin
         check_frame0("t4a", 0);
         check_frame0("t4b", 8);
      end
      ndone = 0;
      foreach (cap0[k]) if (cap0[k][16]) ndone++;
      check("t4_done_cnt", 0, ndone, 2);
      cap0.delete(); t0.delete();

      // Asynchronous reset mid-frame
      pulse_start(0);
      guard = 0;
      while (!(rd_s[0] && addr_s[0] == 18'd5) && guard < 40) begin tick(1); guard++; end
      check("t5_addr5_timeout", 0, longint'(guard < 40), 1);
      #2 rst = 1'b1;
      #1;
      check("t5_busy", 0, longint'(busy_s[0]), 0);
      check("t5_rd", 0, longint'(rd_s[0]), 0);
      check("t5_addr", 0, longint'(addr_s[0]), 0);
      check("t5_valid", 0, longint'(val_s[0]), 0);
      check("t5_data", 0, longint'(data_s[0]), 0);
      check("t5_marks", 0, longint'({sof_s[0], eol_s[0], done_s[0]}), 0);
      cap0.delete(); t0.delete();
      tick(3);
      rst = 1'b0;
      tick(5);
      check("t5_no_valid", 0, cap0.size(), 0);
      pulse_start(0);
      tick(15);
      check("t5_count", 0, cap0.size(), 8);
      if (cap0.size() == 8) check_frame0("t5", 0);

      // Full-width frame
      pulse_start(2);
      guard = 0;
      while (busy_s[2] && guard < 12000) begin tick(1); guard++; end
      check("t6_timeout", 2, longint'(guard < 12000), 1);
      tick(2);
      check("t6_words", 2, cnt_v, 10240);
      check("t6_eols", 2, cnt_eol, 32);
      check("t6_dones", 2, cnt_done, 1);
      check("t6_last_addr", 2, last_addr, 10239);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
